// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM states, ASCII codes
// and the two fixed reply lines.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KEY     = 3'd1,
    ST_EQ      = 3'd2,
    ST_DIG     = 3'd3,
    ST_RESULT  = 3'd4,
    ST_REQ     = 3'd5,
    ST_WAIT_TX = 3'd6
  } state_t;

  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_Z  = 8'h5A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_O  = 8'h4F;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_R  = 8'h52;

  localparam logic [7:0] REPLY_LEN = 8'd4;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= CH_A) && (c <= CH_Z);
  endfunction

  // Byte 0 sits in the low bits, so the reply reads {LF, CR, 2nd, 1st}.
  function automatic logic [31:0] reply_word(input logic ok);
    return ok ? {CH_LF, CH_CR, CH_K, CH_O} : {CH_LF, CH_CR, CH_R, CH_E};
  endfunction

endpackage

// File: rtl/uart_cmd_dec_acc.sv
// Decimal accumulator: acc = acc*10 + digit with a 36-bit overflow check.
// The post-digit value and overflow flag are visible in the strobe cycle.
module uart_cmd_dec_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        digit_stb,
  input  logic [3:0]  digit,
  output logic [31:0] value,
  output logic        overflow
);

  logic [31:0] acc;
  logic [35:0] next_acc;

  // 0xFFFFFFFF*10+9 still fits in 36 bits, so the top nibble flags overflow.
  assign next_acc = ({4'd0, acc} * 36'd10) + {32'd0, digit};
  assign value    = digit_stb ? next_acc[31:0] : acc;
  assign overflow = digit_stb && (next_acc[35:32] != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (digit_stb && !overflow) begin
      acc <= next_acc[31:0];
    end
  end

endmodule

// File: rtl/uart_cmd_parse.sv
// Parses "KEY=DIGITS[CR][LF]" lines one byte per clock, reports the command
// and hands an OK/ER reply to the string transmitter.
module uart_cmd_parse
  import uart_cmd_pkg::*;
#(
  parameter int MAX_DIGITS = 10,
  parameter int STR_W      = 1024
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [STR_W-1:0] rx_string,
  input  logic [7:0]       rx_length,
  input  logic             rx_done,
  output logic [STR_W-1:0] tx_string,
  output logic [7:0]       tx_length,
  output logic             tx_req,
  input  logic             tx_busy,
  input  logic             tx_done,
  output logic             cmd_valid,
  output logic [7:0]       cmd_key,
  output logic [31:0]      cmd_value,
  output logic             cmd_err,
  output logic [7:0]       drop_cnt
);

  localparam int SLOTS = STR_W / 8;
  localparam int IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  state_t           state;
  logic [STR_W-1:0] rx_buf;
  logic [7:0]       rx_len;
  logic [7:0]       idx;
  logic [7:0]       dig_cnt;
  logic [7:0]       key_buf;
  logic             seen_cr;
  logic             seen_lf;

  logic [IW-1:0]    slot;
  logic             in_range;
  logic [7:0]       cur_byte;
  logic             last_byte;
  logic             eol_seen;
  logic             dig_full;
  logic             byte_ok;
  logic             acc_clear;
  logic             acc_stb;
  logic [31:0]      acc_value;
  logic             acc_ovf;

  // Bytes past the end of the bus read as 0, which the grammar rejects.
  assign slot      = idx[IW-1:0];
  assign in_range  = ({24'd0, idx} < 32'(SLOTS));
  assign cur_byte  = in_range ? rx_buf[{slot, 3'b000} +: 8] : 8'h00;
  assign last_byte = (idx == (rx_len - 8'd1));
  assign eol_seen  = seen_cr | seen_lf;
  assign dig_full  = (dig_cnt >= 8'(MAX_DIGITS));

  assign acc_clear = (state == ST_IDLE);
  assign acc_stb   = (state == ST_DIG) && is_digit(cur_byte) && !eol_seen && !dig_full;

  // Combinational so a request can never coincide with a busy transmitter.
  assign tx_req = (state == ST_REQ) && !tx_busy;

  uart_cmd_dec_acc u_acc (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .clear     (acc_clear),
    .digit_stb (acc_stb),
    .digit     (cur_byte[3:0]),
    .value     (acc_value),
    .overflow  (acc_ovf)
  );

  always_comb begin
    byte_ok = 1'b0;
    case (state)
      ST_KEY: byte_ok = (rx_len >= 8'd3) && is_upper(cur_byte);
      ST_EQ:  byte_ok = (cur_byte == CH_EQ);
      ST_DIG: begin
        if (is_digit(cur_byte)) begin
          byte_ok = !eol_seen && !dig_full && !acc_ovf;
        end else if (cur_byte == CH_CR) begin
          byte_ok = (dig_cnt != 8'd0) && !eol_seen;
        end else if (cur_byte == CH_LF) begin
          byte_ok = (dig_cnt != 8'd0) && !seen_lf;
        end
      end
      default: byte_ok = 1'b0;
    endcase
  end

  // Result outputs are registered on the last scanned byte so the pulse
  // lines up with the RESULT state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      rx_buf    <= '0;
      rx_len    <= '0;
      idx       <= '0;
      dig_cnt   <= '0;
      key_buf   <= '0;
      seen_cr   <= 1'b0;
      seen_lf   <= 1'b0;
      tx_string <= '0;
      tx_length <= '0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_key   <= '0;
      cmd_value <= '0;
      drop_cnt  <= '0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;

      if (rx_done && (state != ST_IDLE) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (rx_done) begin
            rx_buf  <= rx_string;
            rx_len  <= rx_length;
            idx     <= '0;
            dig_cnt <= '0;
            seen_cr <= 1'b0;
            seen_lf <= 1'b0;
            state   <= ST_KEY;
          end
        end

        ST_KEY, ST_EQ, ST_DIG: begin
          if (!byte_ok) begin
            cmd_err   <= 1'b1;
            tx_string <= {{(STR_W-32){1'b0}}, reply_word(1'b0)};
            tx_length <= REPLY_LEN;
            state     <= ST_RESULT;
          end else begin
            idx <= idx + 8'd1;
            if (state == ST_KEY) begin
              key_buf <= cur_byte;
              state   <= ST_EQ;
            end else if (state == ST_EQ) begin
              state <= ST_DIG;
            end else begin
              if (is_digit(cur_byte)) dig_cnt <= dig_cnt + 8'd1;
              if (cur_byte == CH_CR)  seen_cr <= 1'b1;
              if (cur_byte == CH_LF)  seen_lf <= 1'b1;
              if (last_byte) begin
                cmd_valid <= 1'b1;
                cmd_key   <= key_buf;
                cmd_value <= acc_value;
                tx_string <= {{(STR_W-32){1'b0}}, reply_word(1'b1)};
                tx_length <= REPLY_LEN;
                state     <= ST_RESULT;
              end
            end
          end
        end

        ST_RESULT:  state <= ST_REQ;
        ST_REQ:     if (!tx_busy) state <= ST_WAIT_TX;
        ST_WAIT_TX: if (tx_done) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parse.sv
// Directed, table-driven bench for uart_cmd_parse with hand-computed
// outcomes, latencies and reply lines.
module tb_uart_cmd_parse;

  localparam int STR_W      = 1024;
  localparam int MAX_DIGITS = 10;
  localparam logic [31:0] OK_WORD = 32'h0A0D4B4F;
  localparam logic [31:0] ER_WORD = 32'h0A0D5245;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [STR_W-1:0] rx_string;
  logic [7:0]       rx_length;
  logic             rx_done;
  logic [STR_W-1:0] tx_string;
  logic [7:0]       tx_length;
  logic             tx_req;
  logic             tx_busy;
  logic             tx_done;
  logic             cmd_valid;
  logic [7:0]       cmd_key;
  logic [31:0]      cmd_value;
  logic             cmd_err;
  logic [7:0]       drop_cnt;

  uart_cmd_parse #(.MAX_DIGITS(MAX_DIGITS), .STR_W(STR_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_string (rx_string),
    .rx_length (rx_length),
    .rx_done   (rx_done),
    .tx_string (tx_string),
    .tx_length (tx_length),
    .tx_req    (tx_req),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .cmd_valid (cmd_valid),
    .cmd_key   (cmd_key),
    .cmd_value (cmd_value),
    .cmd_err   (cmd_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       line;
    bit          exp_ok;
    logic [7:0]  exp_key;
    logic [31:0] exp_value;
    int          exp_lat;
    int          busy;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  model_key = '0;
  logic [31:0] model_value = '0;
  int          model_drop = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge sys_clk);
  endtask

  function automatic void add_vec(input string line, input bit ok, input logic [7:0] key,
                                  input logic [31:0] val, input int lat, input int busy, input string name);
    vec_t v;
    v.line = line; v.exp_ok = ok; v.exp_key = key; v.exp_value = val;
    v.exp_lat = lat; v.busy = busy; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic load_line(input string s);
    rx_string = '0;
    for (int i = 0; i < s.len(); i++) rx_string[i*8 +: 8] = s[i];
    rx_length = 8'(s.len());
  endtask

  task automatic bump_drop();
    if (model_drop < 255) model_drop++;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " cmd_valid"}, cmd_valid, 0);
    check_output({tag, " cmd_err"}, cmd_err, 0);
    check_output({tag, " tx_req"}, tx_req, 0);
    check_output({tag, " cmd_key"}, cmd_key, 0);
    check_output({tag, " cmd_value"}, cmd_value, 0);
    check_output({tag, " tx_length"}, tx_length, 0);
    check_output({tag, " drop_cnt"}, drop_cnt, 0);
    check_output({tag, " tx_string"}, {63'd0, |tx_string}, 0);
  endtask

  // Reply handshake: optional busy stretch, drops during WAIT_TX, then tx_done.
  task automatic handle_tx(input string name, input int busy, input int drops, input bit drop_at_done);
    int   c;
    bit   got;
    logic quiet;
    got = 0;
    c = 0;
    while (!got && c < 200) begin
      next_cycle();
      c++;
      tx_busy = (c <= busy);
      to_sample();
      if (c == 1) check_output({name, " pulse width"}, {63'd0, cmd_valid | cmd_err}, 0);
      if (tx_req) got = 1;
    end
    check_output({name, " tx_req cycle"}, c, busy + 1);
    quiet = 1'b0;
    for (int d = 0; d < drops; d++) begin
      next_cycle();
      rx_done = 1'b1;
      bump_drop();
      to_sample();
      quiet |= cmd_valid | cmd_err | tx_req;
      next_cycle();
      rx_done = 1'b0;
      to_sample();
      quiet |= cmd_valid | cmd_err | tx_req;
    end
    next_cycle();
    tx_done = 1'b1;
    rx_done = drop_at_done;
    if (drop_at_done) bump_drop();
    to_sample();
    quiet |= tx_req;
    next_cycle();
    tx_done = 1'b0;
    rx_done = 1'b0;
    to_sample();
    check_output({name, " drop_cnt"}, drop_cnt, model_drop);
    for (int q = 0; q < 5; q++) begin
      next_cycle();
      to_sample();
      quiet |= cmd_valid | cmd_err | tx_req;
    end
    check_output({name, " no extra pulses"}, {63'd0, quiet}, 0);
  endtask

  task automatic apply_stimulus(input vec_t v, input int drops, input bit drop_at_done);
    int   n;
    bit   seen;
    logic got_valid;
    logic got_err;
    next_cycle();
    load_line(v.line);
    rx_done = 1'b1;
    seen = 0;
    n = 0;
    got_valid = 1'b0;
    got_err = 1'b0;
    while (!seen && n < 300) begin
      next_cycle();
      rx_done = 1'b0;
      n++;
      to_sample();
      if (cmd_valid || cmd_err) begin
        seen = 1;
        got_valid = cmd_valid;
        got_err = cmd_err;
      end
    end
    if (!seen) begin
      check_output({v.name, " result timeout"}, 0, 1);
      return;
    end
    if (v.exp_ok) begin
      model_key = v.exp_key;
      model_value = v.exp_value;
    end
    check_output({v.name, " latency"}, n, v.exp_lat);
    check_output({v.name, " cmd_valid"}, got_valid, v.exp_ok);
    check_output({v.name, " cmd_err"}, got_err, !v.exp_ok);
    check_output({v.name, " cmd_key"}, cmd_key, model_key);
    check_output({v.name, " cmd_value"}, cmd_value, model_value);
    check_output({v.name, " tx_length"}, tx_length, 4);
    check_output({v.name, " tx reply"}, tx_string[31:0], v.exp_ok ? OK_WORD : ER_WORD);
    check_output({v.name, " tx upper"}, {63'd0, |tx_string[STR_W-1:32]}, 0);
    handle_tx(v.name, v.busy, drops, drop_at_done);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    vec_t v;
    logic quiet;

    add_vec("F=12345\015\012",  1'b1, 8'h46, 32'd12345,     10, 0,  "f_crlf");
    add_vec("A=4294967295",     1'b1, 8'h41, 32'hFFFFFFFF,  13, 0,  "max_value");
    add_vec("A=4294967296",     1'b0, 8'h00, 32'd0,         13, 0,  "overflow");
    add_vec("f=1",              1'b0, 8'h00, 32'd0,         2,  0,  "lower_key");
    add_vec("F1",               1'b0, 8'h00, 32'd0,         2,  0,  "short_f1");
    add_vec("F=",               1'b0, 8'h00, 32'd0,         2,  0,  "short_feq");
    add_vec("F=12x",            1'b0, 8'h00, 32'd0,         6,  0,  "bad_char");
    add_vec("F=1\0152",         1'b0, 8'h00, 32'd0,         6,  0,  "digit_after_cr");
    add_vec("",                 1'b0, 8'h00, 32'd0,         2,  0,  "len_zero");
    add_vec("Z=0",              1'b1, 8'h5A, 32'd0,         4,  0,  "key_z_zero");
    add_vec("A=7\012",          1'b1, 8'h41, 32'd7,         5,  0,  "lf_only");
    add_vec("Q=00000000001",    1'b0, 8'h00, 32'd0,         14, 0,  "too_many_digits");
    add_vec("B=0000000042",     1'b1, 8'h42, 32'd42,        13, 0,  "ten_digits");
    add_vec("F=\015\012",       1'b0, 8'h00, 32'd0,         4,  0,  "no_digits");
    add_vec("@=1",              1'b0, 8'h00, 32'd0,         2,  0,  "key_below_a");
    add_vec("F:1",              1'b0, 8'h00, 32'd0,         3,  0,  "no_equals");
    add_vec("K=65535\015",      1'b1, 8'h4B, 32'd65535,     9,  20, "busy_stretch");

    sys_rst_n = 1'b0;
    rx_string = '0;
    rx_length = '0;
    rx_done   = 1'b0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    repeat (3) next_cycle();
    to_sample();
    check_reset_values("reset");
    next_cycle();
    sys_rst_n = 1'b1;

    foreach (vecs[i]) apply_stimulus(vecs[i], 0, 1'b0);

    // Two drops while waiting plus one coinciding with tx_done.
    v.line = "D=5"; v.exp_ok = 1'b1; v.exp_key = 8'h44; v.exp_value = 32'd5;
    v.exp_lat = 4; v.busy = 0; v.name = "drop3";
    apply_stimulus(v, 2, 1'b1);

    v.line = "E=6"; v.exp_key = 8'h45; v.exp_value = 32'd6; v.name = "drop_saturate";
    apply_stimulus(v, 300, 1'b0);

    // Reset while scanning digits abandons the line silently.
    next_cycle();
    load_line("F=12345");
    rx_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      rx_done = 1'b0;
    end
    #1 sys_rst_n = 1'b0;
    #1 check_reset_values("mid_dig_reset");
    model_key = '0;
    model_value = '0;
    model_drop = 0;
    quiet = 1'b0;
    repeat (3) begin
      next_cycle();
      to_sample();
      quiet |= cmd_valid | cmd_err | tx_req;
    end
    check_output("mid_dig_reset quiet", {63'd0, quiet}, 0);
    next_cycle();
    sys_rst_n = 1'b1;

    v.line = "R=77"; v.exp_ok = 1'b1; v.exp_key = 8'h52; v.exp_value = 32'd77;
    v.exp_lat = 5; v.busy = 0; v.name = "after_reset";
    apply_stimulus(v, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
